// File: rtl/instruction_memory_loader.sv
// Byte-stream program loader into a synchronous single-port-read instruction memory.
// Bytes are assembled little-endian into words; a load ends on HALT_WORD or when memory fills.
module instruction_memory_loader #(
  parameter int unsigned        NB_DATA   = 32,
  parameter int unsigned        NB_ADDR   = 6,
  parameter bit                 OUT_REG   = 1'b1,
  parameter logic [NB_DATA-1:0] HALT_WORD = {NB_DATA{1'b1}}
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_load_start,
  input  logic               i_byte_valid,
  input  logic [7:0]         i_byte,
  input  logic               i_read_enable,
  input  logic [NB_ADDR-1:0] i_read_addr,
  input  logic               i_regce,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_load_busy,
  output logic               o_load_done,
  output logic [NB_ADDR:0]   o_word_count,
  output logic               o_overflow
);

  localparam int unsigned NB_LANES = NB_DATA / 8;
  localparam int unsigned NB_BCNT  = (NB_LANES > 1) ? $clog2(NB_LANES) : 1;
  localparam int unsigned DEPTH    = 2 ** NB_ADDR;

  localparam logic [NB_BCNT-1:0] LAST_LANE = NB_BCNT'(NB_LANES - 1);
  localparam logic [NB_ADDR-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  state_e             state_q;
  logic [NB_BCNT-1:0] byte_cnt_q;
  logic [NB_ADDR-1:0] wr_ptr_q;
  logic [NB_ADDR:0]   word_count_q;
  logic               overflow_q;
  logic               load_busy_q;
  logic               load_done_q;
  logic [NB_DATA-1:0] asm_q;
  logic [NB_DATA-1:0] stage1_q;

  logic [NB_DATA-1:0] mem [DEPTH];

  logic [NB_DATA-1:0] word_assembled;
  logic               byte_write;
  logic               word_write;

  // Current byte merged into the assembly register so the word can be written on the same edge.
  always_comb begin
    word_assembled = asm_q;
    for (int l = 0; l < NB_LANES; l++) begin
      if (byte_cnt_q == NB_BCNT'(l)) word_assembled[l*8 +: 8] = i_byte;
    end
    byte_write = (state_q == StLoad) && i_byte_valid;
    word_write = byte_write && (byte_cnt_q == LAST_LANE);
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= StIdle;
      byte_cnt_q   <= '0;
      wr_ptr_q     <= '0;
      word_count_q <= '0;
      overflow_q   <= 1'b0;
      load_busy_q  <= 1'b0;
      load_done_q  <= 1'b0;
      asm_q        <= '0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (i_load_start) begin
            state_q      <= StLoad;
            load_busy_q  <= 1'b1;
            load_done_q  <= 1'b0;
            byte_cnt_q   <= '0;
            wr_ptr_q     <= '0;
            word_count_q <= '0;
            overflow_q   <= 1'b0;
          end
        end
        StLoad: begin
          if (byte_write) begin
            asm_q <= word_assembled;
            if (word_write) begin
              byte_cnt_q   <= '0;
              word_count_q <= word_count_q + 1'b1;
              // Pointer saturates at the last address instead of wrapping.
              if (wr_ptr_q != LAST_ADDR) wr_ptr_q <= wr_ptr_q + 1'b1;
              if (word_assembled == HALT_WORD) begin
                state_q     <= StDone;
                load_busy_q <= 1'b0;
                load_done_q <= 1'b1;
                overflow_q  <= 1'b0;
              end else if (wr_ptr_q == LAST_ADDR) begin
                state_q     <= StDone;
                load_busy_q <= 1'b0;
                load_done_q <= 1'b1;
                overflow_q  <= 1'b1;
              end
            end else begin
              byte_cnt_q <= byte_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q     <= StIdle;
          load_busy_q <= 1'b0;
          load_done_q <= 1'b0;
        end
      endcase
    end
  end

  // Memory has no reset so a reset mid-load keeps already written words.
  always_ff @(posedge i_clock) begin
    if (word_write) mem[wr_ptr_q] <= word_assembled;
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      stage1_q <= '0;
    end else if (i_read_enable) begin
      stage1_q <= mem[i_read_addr];
    end
  end

  generate
    if (OUT_REG) begin : g_out_reg
      logic [NB_DATA-1:0] stage2_q;
      always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
          stage2_q <= '0;
        end else if (i_regce) begin
          stage2_q <= stage1_q;
        end
      end
      assign o_data = stage2_q;
    end else begin : g_no_out_reg
      assign o_data = stage1_q;
    end
  endgenerate

  assign o_load_busy  = load_busy_q;
  assign o_load_done  = load_done_q;
  assign o_word_count = word_count_q;
  assign o_overflow   = overflow_q;

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Directed bench: default config (a), OUT_REG=0 (b) sharing one stream, NB_ADDR=2 (c) for overflow.
module tb_instruction_memory_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        valid = 1'b0;
  logic [7:0]  bval = '0;
  logic        re = 1'b0;
  logic [5:0]  raddr = '0;
  logic        regce = 1'b1;
  logic        sel_c = 1'b0;

  logic [31:0] a_data, b_data, c_data;
  logic        a_busy, b_busy, c_busy, a_done, b_done, c_done, a_ovf, b_ovf, c_ovf;
  logic [6:0]  a_cnt, b_cnt;
  logic [2:0]  c_cnt;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wire ab_start = start & ~sel_c;
  wire ab_valid = valid & ~sel_c;
  wire c_start  = start & sel_c;
  wire c_valid  = valid & sel_c;

  instruction_memory_loader #(.NB_DATA(32), .NB_ADDR(6), .OUT_REG(1'b1)) dut_a (
    .i_clock(clk), .i_reset_n(rst_n), .i_load_start(ab_start), .i_byte_valid(ab_valid),
    .i_byte(bval), .i_read_enable(re), .i_read_addr(raddr), .i_regce(regce),
    .o_data(a_data), .o_load_busy(a_busy), .o_load_done(a_done), .o_word_count(a_cnt),
    .o_overflow(a_ovf)
  );

  instruction_memory_loader #(.NB_DATA(32), .NB_ADDR(6), .OUT_REG(1'b0)) dut_b (
    .i_clock(clk), .i_reset_n(rst_n), .i_load_start(ab_start), .i_byte_valid(ab_valid),
    .i_byte(bval), .i_read_enable(re), .i_read_addr(raddr), .i_regce(regce),
    .o_data(b_data), .o_load_busy(b_busy), .o_load_done(b_done), .o_word_count(b_cnt),
    .o_overflow(b_ovf)
  );

  instruction_memory_loader #(.NB_DATA(32), .NB_ADDR(2), .OUT_REG(1'b0)) dut_c (
    .i_clock(clk), .i_reset_n(rst_n), .i_load_start(c_start), .i_byte_valid(c_valid),
    .i_byte(bval), .i_read_enable(re), .i_read_addr(raddr[1:0]), .i_regce(regce),
    .o_data(c_data), .o_load_busy(c_busy), .o_load_done(c_done), .o_word_count(c_cnt),
    .o_overflow(c_ovf)
  );

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] exp;
  } rd_vec_t;

  rd_vec_t tbl [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    valid = 1'b1;
    bval  = b;
    tick();
    valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[i*8 +: 8]);
  endtask

  task automatic check_ab_reset(input string tag);
    check({tag, "_a_data"}, a_data, 32'h0);
    check({tag, "_b_data"}, b_data, 32'h0);
    check({tag, "_flags"}, {28'h0, a_busy, a_done, a_ovf, b_busy}, 32'h0);
    check({tag, "_a_cnt"}, {25'h0, a_cnt}, 32'h0);
    check({tag, "_b_cnt"}, {25'h0, b_cnt}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{addr: 6'd0, exp: 32'h0000000A};
    tbl[1] = '{addr: 6'd1, exp: 32'h00000014};
    tbl[2] = '{addr: 6'd2, exp: 32'hFFFFFFFF};

    #3;
    check_ab_reset("reset");
    check("reset_c", {c_data[27:0], c_busy, c_done, c_ovf, 1'b0}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Basic load terminated by the halt word
    pulse_start();
    check("load_busy", {31'h0, a_busy}, 32'h1);
    send_word(32'h0000000A);
    send_word(32'h00000014);
    check("mid_cnt", {25'h0, a_cnt}, 32'd2);
    send_word(32'hFFFFFFFF);
    check("load_cnt", {25'h0, a_cnt}, 32'd3);
    check("load_done", {29'h0, a_done, a_busy, a_ovf}, 32'b100);
    check("load_b_cnt", {25'h0, b_cnt}, 32'd3);

    // Pipelined reads: b shows data one edge later, a two edges later
    re = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) raddr = tbl[i].addr;
      tick();
      if (i < 3) check($sformatf("rd_b%0d", i), b_data, tbl[i].exp);
      if (i >= 1) check($sformatf("rd_a%0d", i - 1), a_data, tbl[i-1].exp);
    end
    re = 1'b0;

    // Output register hold while stage 1 updates
    re = 1'b1; raddr = 6'd0;
    tick(); tick();
    check("regce_pre", a_data, 32'h0000000A);
    regce = 1'b0; raddr = 6'd2;
    tick();
    re = 1'b0;
    check("regce_s1", b_data, 32'hFFFFFFFF);
    check("regce_hold", a_data, 32'h0000000A);
    tick();
    check("regce_hold2", a_data, 32'h0000000A);
    regce = 1'b1;
    tick();
    check("regce_rel", a_data, 32'hFFFFFFFF);

    // Same-edge read/write of address 1 returns old contents
    pulse_start();
    check("reload_cnt", {25'h0, a_cnt}, 32'd0);
    send_word(32'h00000055);
    send_byte(8'h66); send_byte(8'h00); send_byte(8'h00);
    valid = 1'b1; bval = 8'h00; re = 1'b1; raddr = 6'd1;
    tick();
    valid = 1'b0;
    check("rw_old", b_data, 32'h00000014);
    tick();
    re = 1'b0;
    check("rw_new_b", b_data, 32'h00000066);
    tick();
    check("rw_new_a", a_data, 32'h00000066);
    send_word(32'hFFFFFFFF);
    check("rw_done", {31'h0, a_done}, 32'h1);

    // Reset mid-load keeps written words
    pulse_start();
    send_word(32'h11223344);
    send_byte(8'hAA); send_byte(8'hBB);
    rst_n = 1'b0;
    #2;
    check_ab_reset("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    re = 1'b1; raddr = 6'd0;
    tick();
    re = 1'b0;
    check("rst_keep_b", b_data, 32'h11223344);
    tick();
    check("rst_keep_a", a_data, 32'h11223344);

    // Overflow on a 4-word memory
    sel_c = 1'b1;
    pulse_start();
    send_word(32'd1);
    send_word(32'd2);
    check("ovf_cnt2", {29'h0, c_cnt}, 32'd2);
    pulse_start();
    check("ovf_start_ign", {28'h0, c_cnt, c_busy}, {28'h0, 3'd2, 1'b1});
    send_word(32'd3);
    send_word(32'd4);
    check("ovf_flags", {29'h0, c_ovf, c_done, c_busy}, 32'b110);
    check("ovf_cnt4", {29'h0, c_cnt}, 32'd4);
    send_word(32'd5);
    check("ovf_ignore", {29'h0, c_cnt}, 32'd4);
    re = 1'b1; raddr = 6'd0;
    tick();
    check("ovf_mem0", c_data, 32'd1);
    raddr = 6'd3;
    tick();
    re = 1'b0;
    check("ovf_mem3", c_data, 32'd4);
    sel_c = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_memory_loader.md
INSTRUCTION_MEMORY_LOADER -- requirements
Module: instruction_memory_loader

Interface
REQ-001 Parameter NB_DATA, default 32: word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter NB_ADDR, default 6: address width; memory depth SHALL be 2**NB_ADDR words.
REQ-003 Parameter OUT_REG, default 1: 0 gives one output stage, 1 adds a second output stage gated by i_regce.
REQ-004 Parameter HALT_WORD, default 32'hFFFFFFFF: word value that terminates a load.
REQ-005 i_clock  in  1  single clock; all state changes on its rising edge.
REQ-006 i_reset_n  in  1  asynchronous, active-low reset.
REQ-007 i_load_start  in  1  one-cycle pulse that starts a program load.
REQ-008 i_byte_valid  in  1  i_byte carries a valid byte this cycle.
REQ-009 i_byte  in  8  program byte stream, little-endian (first byte goes to bits [7:0]).
REQ-010 i_read_enable  in  1  read strobe.
REQ-011 i_read_addr  in  NB_ADDR  read word address.
REQ-012 i_regce  in  1  output-register clock enable; ignored when OUT_REG=0.
REQ-013 o_data  out  NB_DATA  read data.
REQ-014 o_load_busy  out  1  high while in state LOAD.
REQ-015 o_load_done  out  1  high while in state DONE.
REQ-016 o_word_count  out  NB_ADDR+1  number of words written in the current or last load.
REQ-017 o_overflow  out  1  load filled the memory without receiving HALT_WORD.

Function
REQ-018 FSM states SHALL be IDLE, LOAD and DONE.
REQ-019 IDLE or DONE with i_load_start=1: next state LOAD; byte counter, write pointer, o_word_count and o_overflow cleared to 0.
REQ-020 i_load_start in LOAD SHALL be ignored.
REQ-021 LOAD: each i_byte_valid=1 cycle places i_byte at byte lane [byte counter] of the assembly register and increments the byte counter.
REQ-022 i_byte_valid outside LOAD SHALL be ignored.
REQ-023 On the byte completing a word (counter = NB_DATA/8-1):
- assembled word (including the current byte) written to memory[write pointer] on the same edge;
- write pointer and o_word_count increment;
- byte counter returns to 0.
REQ-024 Completed word equal to HALT_WORD: word written and counted, next state DONE, o_overflow=0.
REQ-025 Completed word at address 2**NB_ADDR-1 not equal to HALT_WORD: word written, next state DONE, o_overflow=1; the write pointer SHALL NOT wrap.
REQ-026 Sync read: i_read_enable=1 at edge N loads memory[i_read_addr] into stage 1 at edge N.
- OUT_REG=0: o_data = stage 1 (latency 1).
- OUT_REG=1: stage 2 loads stage 1 on edges where i_regce=1; o_data = stage 2 (latency 2 with i_regce held high).
REQ-027 i_read_enable=0: stage 1 SHALL hold its value.
REQ-028 Read and write to the same address on the same edge: read returns the old contents (read-first).
REQ-029 Reads SHALL be permitted in every FSM state.

Reset
REQ-030 While i_reset_n=0:
- state IDLE;
- o_data, both output stages, o_word_count, o_overflow, byte counter, write pointer and assembly register = 0;
- o_load_busy=0, o_load_done=0.
REQ-031 Reset SHALL NOT clear memory contents.
REQ-032 Reset during LOAD discards the partial word; words already written SHALL remain readable.

Verification
REQ-033 Load: pulse start, then bytes 0A 00 00 00, 14 00 00 00, FF FF FF FF -> mem[0]=10, mem[1]=20, mem[2]=FFFFFFFF; o_word_count=3; o_load_done=1; o_overflow=0.
REQ-034 OUT_REG=1, i_regce=1, read addresses 0, 1, 2 on consecutive cycles -> o_data=10, 20, FFFFFFFF two cycles after each address.
- Repeat with OUT_REG=0 -> same data, one cycle after each address.
REQ-035 Overflow: NB_ADDR=2, load 4 non-halt words 1, 2, 3, 4 -> o_overflow=1, o_word_count=4, DONE.
- Further bytes ignored; mem[0] still 1.
REQ-036 Reset mid-load: mem[0]=0x11223344 loaded, 2 bytes of word 1 sent, assert reset -> state IDLE, outputs 0.
- Subsequent read of address 0 -> 0x11223344.
REQ-037 Same-edge read/write of address 1 during a load -> o_data shows old mem[1]; a read the next cycle returns the new word.
REQ-038 i_regce=0 with OUT_REG=1 -> o_data holds its value while stage 1 updates.
